// File: rtl/alu_mdu.sv
// Execute-stage ALU plus an iterative multiply/divide unit that owns HI/LO.
// Define ALU_MDU_DIV_EN to build the restoring divider; without it DIV/DIVU are no-ops.
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] outcome,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [WIDTH-1:0] LastCnt = WIDTH'(WIDTH - 1);

  // ---------------------------------------------------------------- ALU
  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    outcome = '0;
    case (ALUOp)
      ALU_ADD:  outcome = A + B;
      ALU_SUB:  outcome = A - B;
      ALU_OR:   outcome = A | B;
      ALU_AND:  outcome = A & B;
      ALU_XOR:  outcome = A ^ B;
      ALU_SLL:  outcome = A << shamt;
      ALU_SRL:  outcome = A >> shamt;
      ALU_SRA:  outcome = $signed(A) >>> shamt;
      ALU_SLT:  outcome = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: outcome = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_NOR:  outcome = ~(A | B);
      ALU_LUI:  outcome = B << (WIDTH / 2);
      default:  outcome = '0;
    endcase
  end

  // ---------------------------------------------------------------- MDU
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               accept, start_mul, start_div, op_signed, sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept    = md_start && (state_q == S_IDLE);
  assign start_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign sgn_a     = op_signed & A[WIDTH-1];
  assign sgn_b     = op_signed & B[WIDTH-1];
  assign mag_a     = sgn_a ? -A : A;
  assign mag_b     = sgn_b ? -B : B;

  // Shift-add: acc holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_res;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = neg_q ? -mul_next : mul_next;

`ifdef ALU_MDU_DIV_EN
  logic               is_div_q, is_div_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Restoring divide: acc holds {partial remainder, dividend bits becoming quotient}.
  assign start_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = rem_sh - {1'b0, mcand_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  // A zero divisor leaves |A| as remainder, which sign-corrects back to A; only the quotient is forced.
  assign quo_res   = div0_q ? '1 : (neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
  assign rem_res   = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  assign step_next = is_div_q ? div_next : mul_next;
  assign res_hi    = is_div_q ? rem_res : mul_res[2*WIDTH-1:WIDTH];
  assign res_lo    = is_div_q ? quo_res : mul_res[WIDTH-1:0];

  always_comb begin
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    if (accept && (start_mul || start_div)) begin
      is_div_d  = start_div;
      neg_rem_d = sgn_a;
      div0_d    = (B == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end
`else
  assign start_div = 1'b0;
  assign step_next = mul_next;
  assign res_hi    = mul_res[2*WIDTH-1:WIDTH];
  assign res_lo    = mul_res[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (start_mul || start_div)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, (start_div ? mag_a : mag_b)};
          mcand_d = start_div ? mag_b : mag_a;
          neg_d   = sgn_a ^ sgn_b;
        end else if (accept && (md_op == MD_MTHI)) begin
          hi_d = A;
        end else if (accept && (md_op == MD_MTLO)) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        acc_d = step_next;
        cnt_d = cnt_q + WIDTH'(1);
        if (cnt_q == LastCnt) begin
          state_d = S_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vectors, literal expectations and a
// cycle-level reference model of busy/HI/LO compared on every falling edge.
module tb_alu_mdu;
  localparam int W = 32;

`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   ALUOp = '0;
  logic [2:0]   md_op = '0;
  logic         md_start = 1'b0;
  logic [W-1:0] outcome, hi, lo;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .outcome  (outcome),
    .md_op    (md_op),
    .md_start (md_start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the op table, using wide signed arithmetic.
  function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int     sh;
    longint sa, sb;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return a & b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return W'(sa >>> sh);
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return ~(a | b);
      4'd11:   return b << 16;
      default: return '0;
    endcase
  endfunction

  // Reference MDU result {hi, lo} from plain 64-bit and integer division rules.
  function automatic logic [63:0] mdu_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      3'd1: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
      3'd2: begin
        if (b == '0) return {a, {W{1'b1}}};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        else return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == '0) return {a, {W{1'b1}}};
        else return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Transaction-level model: an accepted long op completes W edges later.
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [63:0]  m_pend = '0;
  int           m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (md_start) begin
      if (md_op <= 3'd1 || (DIV_EN && md_op <= 3'd3)) begin
        m_pend <= mdu_model(md_op, A, B);
        m_left <= W;
      end else if (md_op == 3'd4) begin
        m_hi <= A;
      end else if (md_op == 3'd5) begin
        m_lo <= A;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left != 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  task automatic alu_chk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
    ALUOp = op;
    A     = a;
    B     = b;
    #1;
    check(name, outcome, exp);
    check({name, "_model"}, outcome, alu_model(op, a, b));
  endtask

  task automatic md_issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    md_op    = op;
    A        = a;
    B        = b;
    md_start = 1'b1;
    @(negedge clk); #1;
    md_start = 1'b0;
    A        = $urandom;
    B        = $urandom;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk); #1;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary, expected completion before t=200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b0;

    alu_chk("sra",  4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000);
    alu_chk("srl",  4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
    alu_chk("slt",  4'd8,  32'h8000_0000, 32'd4,         32'd1);
    alu_chk("sltu", 4'd9,  32'h8000_0000, 32'd4,         32'd0);
    alu_chk("add",  4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    alu_chk("sub",  4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE);
    alu_chk("or",   4'd2,  32'hF0,        32'h0F,        32'hFF);
    alu_chk("and",  4'd3,  32'hF0,        32'h3C,        32'h30);
    alu_chk("xor",  4'd4,  32'hF0,        32'h3C,        32'hCC);
    alu_chk("sll",  4'd5,  32'd1,         32'h3F,        32'h8000_0000);
    alu_chk("nor",  4'd10, 32'h0,         32'h0,         32'hFFFF_FFFF);
    alu_chk("lui",  4'd11, 32'h5,         32'h1234,      32'h1234_0000);
    alu_chk("op12", 4'd12, 32'd5,         32'd6,         32'h0);
    alu_chk("sra0", 4'd7,  32'h7000_0001, 32'd0,         32'h7000_0001);

    md_issue(3'd5, 32'hCAFE, 32'h0);
    check("mtlo", lo, 32'hCAFE);
    check("mtlo_busy", 32'(busy), 32'd0);
    md_issue(3'd4, 32'hBEEF, 32'h0);
    check("mthi", hi, 32'hBEEF);

    md_issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_idle(cyc);
    check("mult_cycles", cyc, 32'd32);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    md_issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    md_issue(3'd2, 32'hFFFF_FFF9, 32'd2);
`ifdef ALU_MDU_DIV_EN
    wait_idle(cyc);
    check("div_cycles", cyc, 32'd32);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    md_issue(3'd3, 32'd5, 32'd0);
    wait_idle(cyc);
    check("divu0_cycles", cyc, 32'd32);
    check("divu0_hi", hi, 32'd5);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    md_issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'h0);
    md_issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    check("divneg_lo", lo, 32'hFFFF_FFFD);
    check("divneg_hi", hi, 32'd1);
`else
    check("div_off_busy", 32'(busy), 32'd0);
    check("div_off_hi", hi, 32'hFFFF_FFFE);
    check("div_off_lo", lo, 32'h0000_0001);
    md_issue(3'd3, 32'd5, 32'd0);
    check("divu_off_busy", 32'(busy), 32'd0);
    check("divu_off_hi", hi, 32'hFFFF_FFFE);
    check("divu_off_lo", lo, 32'h0000_0001);
`endif

    // MTHI pulsed while a multiply is running must be dropped, not queued.
    md_issue(3'd1, 32'h0001_0000, 32'h0003_0000);
    repeat (3) @(negedge clk);
    #1;
    md_op    = 3'd4;
    A        = 32'h1234;
    md_start = 1'b1;
    @(negedge clk); #1;
    md_start = 1'b0;
    wait_idle(cyc);
    check("ign_hi", hi, 32'h3);
    check("ign_lo", lo, 32'h0);
    @(negedge clk); #1;
    check("ign_not_queued", hi, 32'h3);

    md_issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;

    md_issue(3'd0, 32'd6, 32'd7);
    wait_idle(cyc);
    check("mult67_lo", lo, 32'd42);
    check("mult67_hi", hi, 32'd0);

    // md_start held high: a new op is taken one idle sample after each completes.
    @(negedge clk); #1;
    md_op    = 3'd0;
    A        = 32'hFFFF_FFF9;
    B        = 32'd5;
    md_start = 1'b1;
    repeat (70) @(negedge clk);
    #1;
    md_start = 1'b0;
    wait_idle(cyc);
    check("b2b_hi", hi, 32'hFFFF_FFFF);
    check("b2b_lo", lo, 32'hFFFF_FFDD);

    for (int i = 0; i < 4; i++) begin
      md_issue(3'(i % 2), $urandom, $urandom);
      wait_idle(cyc);
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit for the MIPS pipeline. It extends the single-cycle ALU with arithmetic shift and set-less-than operations, and adds an iterative multiply/divide unit (MDU) that owns the HI/LO registers. The execute stage uses `outcome` combinationally and stalls on `busy` while a multiply or divide is in flight.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived; do not override).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `ALUOp` in 4: combinational op select.
- `outcome` out WIDTH: combinational result.
- `md_op` in 3: MDU op select.
- `md_start` in 1: request an MDU op this cycle.
- `busy` out 1: iterative MDU op in progress.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- `ALUOp` encodings and results (purely combinational, no dependence on MDU state):
  - 0 ADD: A+B, modulo 2^WIDTH, no overflow flag.
  - 1 SUB: A−B.
  - 2 OR.
  - 3 AND.
  - 4 XOR.
  - 5 SLL: A<<B[SHW-1:0].
  - 6 SRL: A>>B[SHW-1:0], logical.
  - 7 SRA: A>>>B[SHW-1:0], sign-filled.
  - 8 SLT: signed A<B, result 1 or 0, zero-extended.
  - 9 SLTU: unsigned A<B.
  - 10 NOR.
  - 11 LUI: B<<(WIDTH/2).
  - 12–15: 0.
- `md_op` encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- An op is accepted when `md_start`=1 and `busy`=0. Any `md_start` while `busy`=1 is ignored; there is no queueing.
- MTHI/MTLO: `hi` or `lo` loads A on the accepting edge. `busy` stays 0.
- MULT/MULTU/DIV/DIVU:
  - A and B are latched on the accepting edge.
  - The MDU is an FSM with states IDLE → RUN → IDLE.
  - A WIDTH-bit iteration counter advances once per RUN cycle.
- Multiply: shift-add on operand magnitudes. The 2·WIDTH-bit product is sign-corrected at the end for MULT. `hi` takes the upper half and `lo` the lower half.
- Divide: restoring divide on magnitudes.
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, with the sign of the dividend.
- Divide by zero: `hi`=A latched, `lo`=all ones. Takes the same latency as a normal divide.
- Signed corner case: DIV of −2^(WIDTH−1) by −1 gives `lo`=−2^(WIDTH−1), `hi`=0.
- `hi`/`lo` are unchanged while `busy`=1. They update only on the final RUN edge.
- `reset` asserted mid-operation aborts the op. The FSM returns to IDLE and `hi`/`lo` clear.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, FSM=IDLE, counter=0. `outcome` is combinational and has no reset value.
- `outcome` has zero latency from A, B and `ALUOp`.
- Accepting edge at cycle T:
  - `busy`=1 during cycles T+1 … T+WIDTH.
  - On edge T+WIDTH, `hi`/`lo` are written and `busy` falls.
  - `hi`/`lo` hold the new values from cycle T+WIDTH+1.
  - A new op may be accepted at edge T+WIDTH+1 (back-to-back with 1 idle sample).
- MTHI/MTLO: the value is visible on `hi`/`lo` in the cycle after the accepting edge.
- A and B may change freely after the accepting edge.

## Configuration
- `ALU_MDU_DIV_EN` defined: DIV and DIVU are implemented as described above.
- `ALU_MDU_DIV_EN` undefined: the divider datapath is not built.
  - `md_op` 2 and 3 behave as no-ops: `busy` stays 0 and `hi`/`lo` are unchanged.
  - MULT, MULTU, MTHI and MTLO are unaffected.

## Test plan
- ALU ops, WIDTH=32: A=0x80000000, B=4.
  - SRA → 0xF8000000; SRL → 0x08000000.
  - SLT → 1; SLTU → 0.
  - ADD with A=B=0xFFFFFFFF → 0xFFFFFFFE.
- MULT A=−3, B=7 → `busy` high for exactly 32 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV A=−7, B=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU A=5, B=0 → `hi`=5, `lo`=0xFFFFFFFF. With `ALU_MDU_DIV_EN` undefined, DIV → `busy` stays 0 and `hi`/`lo` unchanged.
- `md_start` pulsed with MTHI A=0x1234 while `busy`=1 → ignored; `hi` ends equal to the multiply result.
- Start MULT, then assert `reset` at busy cycle 10 → `busy`=0, `hi`=`lo`=0 immediately. A fresh MULT 6×7 after reset gives `lo`=42.
